bcd_cascade_display: RTL and testbench

Downstream consumer of the synchronous decade counter. Takes the counter's 4-bit BCD units digit, detects its 9→0 wrap to drive three further cascaded BCD decades (tens, hundreds, thousands), and time-multiplexes all four digits onto a common-anode 7-segment display. Sits between the decade counter and the board's display pins, in the same clock domain as the counter.

---
 rtl/bcd_cascade_display.sv | 96 +++++++++
 tb/tb_bcd_cascade_display.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_cascade_display.sv
// bcd_cascade_display: cascades tens/hundreds/thousands BCD decades off the units counter and scans all four onto a 7-seg display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits above the units.
module bcd_cascade_display #(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [3:0]  units,
    output logic [15:0] count,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        ovf,
    output logic        err
);
    localparam logic [15:0] PRE_MAX = 16'(SCAN_DIV - 1);

    logic [3:0]  r_units, r_tens, r_hund, r_thou;
    logic        r_ovf, r_err;
    logic [15:0] r_pre;
    logic [1:0]  r_idx;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        w_wrap, w_c_tens, w_c_hund, w_c_thou, w_pre_end, w_blank;
    logic [1:0]  w_idx_nxt;
    logic [3:0]  w_digit;
    logic [6:0]  w_seg_nxt;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b0111111;
        endcase
    endfunction

    // Only the exact 9->0 code pair counts; illegal codes never produce a carry.
    assign w_wrap    = (r_units == 4'd9) && (units == 4'd0);
    assign w_c_tens  = w_wrap && (r_tens == 4'd9);
    assign w_c_hund  = w_c_tens && (r_hund == 4'd9);
    assign w_c_thou  = w_c_hund && (r_thou == 4'd9);
    assign w_pre_end = (r_pre == PRE_MAX);
    assign w_idx_nxt = r_idx + 2'd1;
    assign w_digit   = (w_idx_nxt == 2'd0) ? r_units :
                       (w_idx_nxt == 2'd1) ? r_tens  :
                       (w_idx_nxt == 2'd2) ? r_hund  : r_thou;
`ifdef LEADING_ZERO_BLANK_EN
    assign w_blank   = ((w_idx_nxt == 2'd3) && (r_thou == 4'd0)) ||
                       ((w_idx_nxt == 2'd2) && ({r_thou, r_hund} == 8'd0)) ||
                       ((w_idx_nxt == 2'd1) && ({r_thou, r_hund, r_tens} == 12'd0));
`else
    assign w_blank   = 1'b0;
`endif
    assign w_seg_nxt = w_blank ? 7'b1111111 : seg7(w_digit);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_units <= 4'd0;
            r_tens  <= 4'd0;
            r_hund  <= 4'd0;
            r_thou  <= 4'd0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_pre   <= 16'd0;
            r_idx   <= 2'd0;
            r_an    <= 4'b1110;
            r_seg   <= 7'b1000000;
        end else begin
            r_units <= units;
            r_err   <= (units > 4'd9);
            if (w_wrap)   r_tens <= w_c_tens ? 4'd0 : r_tens + 4'd1;
            if (w_c_tens) r_hund <= w_c_hund ? 4'd0 : r_hund + 4'd1;
            if (w_c_hund) r_thou <= w_c_thou ? 4'd0 : r_thou + 4'd1;
            if (w_c_thou) r_ovf  <= 1'b1;
            r_pre <= w_pre_end ? 16'd0 : r_pre + 16'd1;
            if (w_pre_end) begin
                r_idx <= w_idx_nxt;
                r_an  <= ~(4'b0001 << w_idx_nxt);
                r_seg <= w_seg_nxt;
            end
        end
    end

    assign count = {r_thou, r_hund, r_tens, r_units};
    assign seg   = r_seg;
    assign an    = r_an;
    assign ovf   = r_ovf;
    assign err   = r_err;
endmodule

// File: tb/tb_bcd_cascade_display.sv
// tb_bcd_cascade_display: directed vectors feed a scoreboard queue; a monitor compares DUT outputs after every edge.
module tb_bcd_cascade_display;
    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        clr_n = 1'b1;
    logic [3:0]  units = 4'd0;
    logic [15:0] count;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        ovf, err;

    typedef struct packed {
        logic [15:0] c;
        logic        o;
        logic        e;
        logic [3:0]  a;
        logic [6:0]  s;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   n_chk = 0;
    int   n_fail = 0;

    int         m_hi, m_k;
    logic [3:0] m_uq;
    logic       m_ovf, m_err;
    logic [1:0] m_idx;
    logic [6:0] m_seg;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    bcd_cascade_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .clr_n(clr_n), .units(units), .count(count),
        .seg(seg), .an(an), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // hi is the decimal value of {thousands,hundreds,tens}
    function automatic logic [6:0] exp_seg(input int idx, input logic [3:0] uq, input int hi);
        if (idx == 0) return (uq > 4'd9) ? 7'b0111111 : seg_tab[int'(uq)];
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx == 3 && hi < 100) || (idx == 2 && hi < 10) || (idx == 1 && hi == 0)) return 7'b1111111;
`endif
        return (idx == 1) ? seg_tab[hi % 10] : (idx == 2) ? seg_tab[(hi / 10) % 10] : seg_tab[hi / 100];
    endfunction

    function automatic logic [15:0] exp_count();
        return {4'(m_hi / 100), 4'((m_hi / 10) % 10), 4'(m_hi % 10), m_uq};
    endfunction

    task automatic model_reset();
        m_hi = 0; m_k = 0; m_uq = 4'd0; m_ovf = 1'b0; m_err = 1'b0;
        m_idx = 2'd0; m_seg = 7'b1000000;
    endtask

    task automatic step(input logic [3:0] u);
        logic [3:0] uq0;
        int hi0;
        exp_t e;
        @(negedge clk);
        units = u;
        uq0 = m_uq;
        hi0 = m_hi;
        if (uq0 == 4'd9 && u == 4'd0) begin
            if (m_hi == 999) begin
                m_hi = 0;
                m_ovf = 1'b1;
            end else m_hi++;
        end
        m_uq = u;
        m_err = (u > 4'd9);
        m_k++;
        if (m_k % SCAN_DIV == 0) begin
            m_idx = 2'((m_k / SCAN_DIV) % 4);
            m_seg = exp_seg(int'(m_idx), uq0, hi0);
        end
        e.c = exp_count();
        e.o = m_ovf;
        e.e = m_err;
        e.a = ~(4'b0001 << m_idx);
        e.s = m_seg;
        q.push_back(e);
    endtask

    task automatic wrap_once();
        step(4'd9);
        step(4'd0);
    endtask

    // Called right after a step: looks at the state after that step's edge.
    task automatic check_now(input logic [15:0] c, input logic o);
        #7;
        check("count_now", count, c);
        check("ovf_now", ovf, o);
    endtask

    always @(posedge clk) begin
        #1;
        if (clr_n && q.size() > 0) begin
            e_mon = q.pop_front();
            check("count", count, e_mon.c);
            check("ovf", ovf, e_mon.o);
            check("err", err, e_mon.e);
            check("an", an, e_mon.a);
            check("seg", seg, e_mon.s);
        end
    end

    initial begin
        model_reset();
        #1 clr_n = 1'b0;
        #11;
        check("rst_count", count, 16'h0000);
        check("rst_ovf", ovf, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_an", an, 4'b1110);
        check("rst_seg", seg, 7'b1000000);
        #7 clr_n = 1'b1;
        repeat (16) step(4'd0);
        for (int u = 1; u <= 9; u++) step(4'(u));
        step(4'd0);
        check_now(16'h0010, 1'b0);
        step(4'd12);
        step(4'd3);
        step(4'd9);
        step(4'd12);
        step(4'd0);
        check_now(16'h0010, 1'b0);
        repeat (20) step(4'd12);
        step(4'd0);
        while (m_hi != 99) wrap_once();
        step(4'd9);
        check_now(16'h0999, 1'b0);
        step(4'd0);
        check_now(16'h1000, 1'b0);
        while (m_hi != 999) wrap_once();
        step(4'd9);
        check_now(16'h9999, 1'b0);
        step(4'd0);
        check_now(16'h0000, 1'b1);
        repeat (10) step(4'd0);
        check_now(16'h0000, 1'b1);
        repeat (5) wrap_once();
        check_now(16'h0050, 1'b1);
        repeat (38) step(4'd0);
        #7 clr_n = 1'b0;
        #1;
        check("clr_count", count, 16'h0000);
        check("clr_an", an, 4'b1110);
        check("clr_ovf", ovf, 1'b0);
        check("clr_seg", seg, 7'b1000000);
        model_reset();
        #1 clr_n = 1'b1;
        repeat (3) step(4'd3);
        check_now(16'h0003, 1'b0);
        repeat (8) step(4'd3);
        @(negedge clk);
        check("drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "timeout");
    end
endmodule
